// File: rtl/scratchpad_mem_responder.sv
// Memory-side responder for the single-master scratchpad bus: fixed-latency
// single-beat read/write with a one-cycle ready pulse, plus access statistics.
module scratchpad_mem_responder #(
  parameter int ADDR_WIDTH    = 8,
  parameter int DATABUS_WIDTH = 32,
  parameter int DEPTH         = 256,
  parameter int LATENCY       = 2,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_sel,
  input  logic                     mem_w,
  input  logic [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus,
  output logic                     ready,
  output logic [CNT_WIDTH-1:0]     rd_count,
  output logic [CNT_WIDTH-1:0]     wr_count,
  output logic                     addr_err,
  input  logic                     clr_stats
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_RELEASE
  } state_t;

  state_t                   r_state;
  logic [ADDR_WIDTH-1:0]    r_addr;
  logic                     r_we;
  logic [LAT_W-1:0]         r_cnt;
  logic [DATABUS_WIDTH-1:0] r_rdata;
  logic                     r_ready;
  logic [DATABUS_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0]    w_rd_addr;
  logic                     w_rd_oor;
  logic                     w_oor;
  logic                     w_done;
  logic [DATABUS_WIDTH-1:0] w_rd_word;

  // With LATENCY=1 RESP is entered on the capture edge, so the read index
  // must come straight from the bus rather than the not-yet-latched r_addr.
  assign w_rd_addr = (r_state == S_IDLE) ? address_bus : r_addr;
  assign w_rd_oor  = ({1'b0, w_rd_addr} >= LP_DEPTH);
  assign w_oor     = ({1'b0, r_addr} >= LP_DEPTH);
  assign w_done    = (r_state == S_RESP);
  assign w_rd_word = w_rd_oor ? '0 : r_mem[w_rd_addr[IDX_W-1:0]];

  assign ready    = r_ready;
  assign data_bus = (r_state == S_RESP && !r_we) ? r_rdata : 'z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (mem_sel) begin
            r_addr <= address_bus;
            r_we   <= mem_w;
            r_cnt  <= LAT_W'(LATENCY - 1);
            if (LATENCY == 1) begin
              r_state <= S_RESP;
              r_ready <= 1'b1;
              r_rdata <= w_rd_word;
            end else begin
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!mem_sel) begin
            r_state <= S_IDLE;
          end else if (r_cnt == LAT_W'(1)) begin
            r_state <= S_RESP;
            r_ready <= 1'b1;
            r_rdata <= w_rd_word;
          end else begin
            r_cnt <= r_cnt - LAT_W'(1);
          end
        end
        S_RESP: begin
          r_state <= S_RELEASE;
          r_ready <= 1'b0;
        end
        S_RELEASE: begin
          if (!mem_sel) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
      wr_count <= '0;
      addr_err <= 1'b0;
    end else if (clr_stats) begin
      rd_count <= '0;
      wr_count <= '0;
      addr_err <= 1'b0;
    end else if (w_done) begin
      if (r_we) wr_count <= wr_count + CNT_WIDTH'(1);
      else      rd_count <= rd_count + CNT_WIDTH'(1);
      if (w_oor) addr_err <= 1'b1;
    end
  end

  // Array is intentionally not reset; a reset while in flight leaves
  // r_state in IDLE so no commit can happen.
  always_ff @(posedge clk) begin
    if (w_done && r_we && !w_oor) r_mem[r_addr[IDX_W-1:0]] <= data_bus;
  end

endmodule

// File: doc/scratchpad_mem_responder.md
Name: scratchpad_mem_responder

Overview:
Responder (memory side) of the shared single-master scratchpad bus used by the accelerator compute blocks (maxpool, conv, etc.). It accepts single-beat read/write requests qualified by mem_sel/mem_w, waits a fixed access latency, then pulses ready for one cycle. During a read's ready cycle it drives data_bus; otherwise data_bus is high-Z. It also keeps access statistics and a sticky out-of-range error flag for bench and debug use.

Parameters:
ADDR_WIDTH, 8, width of address_bus.
DATABUS_WIDTH, 32, width of data_bus and of each memory word.
DEPTH, 256, number of words implemented; must be <= 2**ADDR_WIDTH.
LATENCY, 2, cycles from request capture to ready pulse; must be >= 1.
CNT_WIDTH, 16, width of the statistics counters.

Ports:
clk  input  1  clock, rising-edge.
rst  input  1  reset, asynchronous, active-high.
mem_sel  input  1  request valid from the master.
mem_w  input  1  1 = write, 0 = read; meaningful only while mem_sel = 1.
address_bus  input  ADDR_WIDTH  word address; held stable by the master while mem_sel = 1.
data_bus  inout  DATABUS_WIDTH  master drives it for writes; this block drives it only during a read's ready cycle.
ready  output  1  one-cycle completion pulse.
rd_count  output  CNT_WIDTH  completed reads; wraps modulo 2**CNT_WIDTH.
wr_count  output  CNT_WIDTH  completed writes; wraps modulo 2**CNT_WIDTH.
addr_err  output  1  sticky; set by any completed access with address_bus >= DEPTH.
clr_stats  input  1  synchronous clear of rd_count, wr_count and addr_err.

Behaviour:
- Reset is asynchronous: state = IDLE, ready = 0, data_bus = Z, counters = 0, addr_err = 0, internal latches = 0. Memory array contents are not reset.
- A reset during an in-flight request aborts it. No write is committed and no count is incremented.
- FSM states: IDLE, WAIT, RESP, RELEASE. ready is registered and equals (state == RESP).
- IDLE: on an edge with mem_sel = 1, latch addr_q = address_bus and we_q = mem_w, and load the countdown with LATENCY-1.
  - LATENCY = 1: go to RESP directly.
  - Otherwise: go to WAIT.
- WAIT: decrement the countdown each edge. Go to RESP on the edge where the countdown is 1.
  - If mem_sel = 0 at any WAIT edge, the request is aborted: return to IDLE with no write and no count.
- Latency: ready is high in the cycle exactly LATENCY edges after the edge that captured the request.
- Read data: on entry to RESP, rdata_q = mem[addr_q], or 0 if addr_q >= DEPTH. data_bus = rdata_q while (state == RESP && !we_q), else Z. The master samples data_bus at the edge ending the RESP cycle.
- Write commit: at the edge ending RESP with we_q = 1, mem[addr_q] = data_bus sampled at that edge. The write is dropped if addr_q >= DEPTH.
- Completion at the edge ending RESP:
  - Increment rd_count or wr_count according to we_q.
  - Set addr_err if addr_q >= DEPTH.
  - Go to RELEASE.
- RELEASE: stay while mem_sel = 1; go to IDLE on the first edge with mem_sel = 0. This guarantees one response per request. mem_sel is not re-sampled as a new request in this state.
- The master deasserts mem_sel for at least one cycle after each ready. Back-to-back request period is therefore LATENCY + 2 cycles minimum.
- mem_w and address_bus changes while mem_sel = 0 are ignored. Changes to them after capture (WAIT/RESP) are ignored, because addr_q/we_q are used.
- clr_stats has priority over a same-edge completion: counters end at 0 and addr_err at 0.
- Counter wrap: 2**CNT_WIDTH - 1 followed by one more completion gives 0.
- No combinational path from any input to ready.

Test Plan:
1. Reset: assert rst mid-WAIT of a write to addr 5 -> ready = 0, data_bus = Z, counters 0 immediately; a later read of addr 5 returns the pre-request contents.
2. LATENCY = 2: write 0xDEADBEEF to addr 0x10, then read addr 0x10 -> ready high exactly 2 edges after capture, for one cycle; read returns 0xDEADBEEF on data_bus only during ready; wr_count = 1, rd_count = 1.
3. Maxpool-style burst: 16 sequential reads of addrs 0..15, each followed by a one-cycle mem_sel = 0 gap -> 16 ready pulses, each spaced LATENCY + 2 cycles, correct data each time; rd_count = 16.
4. DEPTH = 16: write 0x55 to addr 20, then read addr 20 -> ready still pulses, read data 0, no array word modified, addr_err = 1 and stays 1 until clr_stats.
5. Abort: mem_sel high one cycle and then low during WAIT (LATENCY = 3) -> no ready, no write, counters unchanged, FSM back to IDLE.
6. mem_sel held high 5 cycles after ready -> exactly one ready pulse. clr_stats asserted on a completion edge -> rd_count = 0, wr_count = 0, addr_err = 0.
